// File: rtl/rank_sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rank_sort_pkg
// Description : Shared types and helpers for the rank sort engine: FSM state
//               encoding, sort-mode encodings and the compare-block count.
// Revision    : 1.0 - initial release
// ============================================================================
package rank_sort_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SORT    = 2'd1,
        SCATTER = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic ASCEND  = 1'b0;
    localparam logic DESCEND = 1'b1;

    // Number of inner compare blocks per row: ceil(dn / lanes).
    function automatic int calc_blocks(input int dn, input int lanes);
        return (dn + lanes - 1) / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rank_sort_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : rank_sort_engine_if
// Description : Run-request / result bundle of the rank sort engine.
//               master = requester side, slave = engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rank_sort_engine_if #(
    parameter int DN = 8,
    parameter int DW = 8
);
    localparam int DN_WIDTH = $clog2(DN);

    logic                   start;
    logic                   descend;
    logic [DW*DN-1:0]       data_in;
    logic                   busy;
    logic                   done;
    logic [DN_WIDTH*DN-1:0] rank_out;
    logic [DW*DN-1:0]       data_sorted;

    modport master (
        output start, descend, data_in,
        input  busy, done, rank_out, data_sorted
    );

    modport slave (
        input  start, descend, data_in,
        output busy, done, rank_out, data_sorted
    );

endinterface
`default_nettype wire

// File: rtl/rank_cmp_lane.sv
`default_nettype none
// ============================================================================
// Module      : rank_cmp_lane
// Description : One pairwise compare lane. Returns 1 when element j must be
//               placed before element i in the selected order; equal values
//               fall back to index order so the ranks stay a permutation.
// Revision    : 1.0 - initial release
// ============================================================================
module rank_cmp_lane
    import rank_sort_pkg::*;
#(
    parameter int DW = 8,
    parameter int IW = 3
) (
    input  wire logic [DW-1:0] d_i,
    input  wire logic [DW-1:0] d_j,
    input  wire logic [IW-1:0] idx_i,
    input  wire logic [IW-1:0] idx_j,
    input  wire logic          valid,
    input  wire logic          descend,
    output logic               contrib
);

    logic w_less;
    logic w_more;
    logic w_tie;

    assign w_less = (d_j < d_i);
    assign w_more = (d_j > d_i);
    assign w_tie  = (d_j == d_i) && (idx_j < idx_i);

    // Masked lanes and the self-compare never contribute.
    assign contrib = valid && (idx_j != idx_i) &&
                     (((descend == DESCEND) ? w_more : w_less) || w_tie);

endmodule
`default_nettype wire

// File: rtl/rank_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : rank_sort_engine
// Description : Multi-lane counting (rank) sort. Compares element i against
//               LANES elements per cycle, accumulates stable ranks, then
//               scatters the words into sorted order and pulses done.
//               Optional feature macro: RANK_SORT_DATA_OUT_EN builds the
//               SCATTER stage and the data_sorted register; without it
//               data_sorted is tied to 0 and ranks publish straight from SORT.
// Revision    : 1.0 - initial release
// ============================================================================
module rank_sort_engine
    import rank_sort_pkg::*;
#(
    parameter int DN    = 8,
    parameter int DW    = 8,
    parameter int LANES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rank_sort_engine_if.slave bus
);

    localparam int DN_WIDTH = $clog2(DN);
    localparam int c_BLOCKS = calc_blocks(DN, LANES);
    localparam int c_JB_W   = (c_BLOCKS > 1) ? $clog2(c_BLOCKS) : 1;
    localparam int c_J_W    = $clog2(c_BLOCKS * LANES) + 1;
    localparam int c_SUM_W  = $clog2(LANES + 1);

    localparam logic [1:0] c_ST_IDLE    = IDLE;
    localparam logic [1:0] c_ST_SORT    = SORT;
    localparam logic [1:0] c_ST_SCATTER = SCATTER;
    localparam logic [1:0] c_ST_DONE    = DONE;

    logic [1:0]             r_state;
    logic [DN_WIDTH-1:0]    r_i;
    logic [c_JB_W-1:0]      r_jb;
    logic                   r_desc;
    logic [DW*DN-1:0]       r_data;
    logic [DN_WIDTH-1:0]    r_rank [DN];
    logic [DN_WIDTH*DN-1:0] r_rank_out;

    logic [DW-1:0]          w_d_i;
    logic [LANES-1:0]       w_hit;
    logic [c_SUM_W-1:0]     w_sum;
    logic                   w_in_sort;
    logic [DN_WIDTH-1:0]    w_rank_nxt [DN];
    logic [DN_WIDTH*DN-1:0] w_rank_flat;

    assign w_d_i     = r_data[r_i*DW +: DW];
    assign w_in_sort = (r_state == c_ST_SORT);

    // Lane l compares element i against element j = jb*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [c_J_W-1:0]    w_j;
        logic                w_valid;
        logic [DN_WIDTH-1:0] w_idx_j;
        logic [DW-1:0]       w_d_j;

        assign w_j     = c_J_W'(r_jb) * c_J_W'(LANES) + c_J_W'(l);
        assign w_valid = (w_j < c_J_W'(DN));
        assign w_idx_j = w_valid ? w_j[DN_WIDTH-1:0] : '0;
        assign w_d_j   = r_data[w_idx_j*DW +: DW];

        rank_cmp_lane #(
            .DW (DW),
            .IW (DN_WIDTH)
        ) u_lane (
            .d_i     (w_d_i),
            .d_j     (w_d_j),
            .idx_i   (r_i),
            .idx_j   (w_idx_j),
            .valid   (w_valid),
            .descend (r_desc),
            .contrib (w_hit[l])
        );
    end

    // Population count of the lane contributions for this cycle.
    always_comb begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum = w_sum + c_SUM_W'(w_hit[l]);
        end
    end

    // Next accumulator values; row i only moves while sorting. Also flattened
    // so the final SORT edge can publish ranks including its own contribution.
    always_comb begin
        for (int k = 0; k < DN; k++) begin
            w_rank_nxt[k] = r_rank[k];
        end
        if (w_in_sort) begin
            w_rank_nxt[r_i] = r_rank[r_i] + DN_WIDTH'(w_sum);
        end
        w_rank_flat = '0;
        for (int k = 0; k < DN; k++) begin
            w_rank_flat[k*DN_WIDTH +: DN_WIDTH] = w_rank_nxt[k];
        end
    end

    // Control FSM, i/jb counters, rank accumulators and published ranks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_i        <= '0;
            r_jb       <= '0;
            r_desc     <= 1'b0;
            r_data     <= '0;
            r_rank_out <= '0;
            for (int k = 0; k < DN; k++) begin
                r_rank[k] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_data  <= bus.data_in;
                        r_desc  <= bus.descend;
                        r_i     <= '0;
                        r_jb    <= '0;
                        r_state <= c_ST_SORT;
                        for (int k = 0; k < DN; k++) begin
                            r_rank[k] <= '0;
                        end
                    end
                end
                c_ST_SORT: begin
                    for (int k = 0; k < DN; k++) begin
                        r_rank[k] <= w_rank_nxt[k];
                    end
                    if (r_jb == c_JB_W'(c_BLOCKS - 1)) begin
                        r_jb <= '0;
                        if (r_i == DN_WIDTH'(DN - 1)) begin
`ifdef RANK_SORT_DATA_OUT_EN
                            r_state <= c_ST_SCATTER;
`else
                            r_rank_out <= w_rank_flat;
                            r_state    <= c_ST_DONE;
`endif
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_jb <= r_jb + 1'b1;
                    end
                end
                c_ST_SCATTER: begin
                    r_rank_out <= w_rank_flat;
                    r_state    <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef RANK_SORT_DATA_OUT_EN
    logic [DW*DN-1:0] r_sorted;

    // Scatter every element to its rank position in one shot; ranks form a
    // permutation, so every slot is rewritten and nothing is left stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sorted <= '0;
        end else if (r_state == c_ST_SCATTER) begin
            for (int k = 0; k < DN; k++) begin
                r_sorted[r_rank[k]*DW +: DW] <= r_data[k*DW +: DW];
            end
        end
    end

    assign bus.data_sorted = r_sorted;
`else
    assign bus.data_sorted = '0;
`endif

    assign bus.busy     = (r_state != c_ST_IDLE);
    assign bus.done     = (r_state == c_ST_DONE);
    assign bus.rank_out = r_rank_out;

endmodule
`default_nettype wire

// File: tb/tb_rank_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_rank_sort_engine
// Description : Self-checking bench for rank_sort_engine (LANES=2 and LANES=3
//               instances). Expected results are queued at stimulus time and
//               popped when the engine reports done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rank_sort_engine;

    localparam int DN = 8;
    localparam int DW = 8;
    localparam int RW = 3;
`ifdef RANK_SORT_DATA_OUT_EN
    localparam bit c_HAS_SORT = 1'b1;
    localparam int c_EXTRA    = 2;
`else
    localparam bit c_HAS_SORT = 1'b0;
    localparam int c_EXTRA    = 1;
`endif
    localparam int c_TIMEOUT = 200;

    localparam logic [DW*DN-1:0] c_DATA      = {8'd6, 8'd2, 8'd9, 8'd5, 8'd1, 8'd4, 8'd1, 8'd3};
    localparam logic [RW*DN-1:0] c_ASC_RANK  = {3'd6, 3'd2, 3'd7, 3'd5, 3'd1, 3'd4, 3'd0, 3'd3};
    localparam logic [DW*DN-1:0] c_ASC_SORT  = {8'd9, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd1};
    localparam logic [RW*DN-1:0] c_DSC_RANK  = {3'd1, 3'd5, 3'd0, 3'd2, 3'd7, 3'd3, 3'd6, 3'd4};
    localparam logic [DW*DN-1:0] c_DSC_SORT  = {8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd9};
    localparam logic [RW*DN-1:0] c_IDX_RANK  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [DW*DN-1:0] c_REV_DATA  = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    localparam logic [RW*DN-1:0] c_REV_RANK  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [DW*DN-1:0] c_REV_SORT  = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

    typedef struct packed {
        logic [RW*DN-1:0] rank;
        logic [DW*DN-1:0] sorted;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rank_sort_engine_if #(.DN(DN), .DW(DW)) bus_a ();
    rank_sort_engine_if #(.DN(DN), .DW(DW)) bus_b ();

    rank_sort_engine #(.DN(DN), .DW(DW), .LANES(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    rank_sort_engine #(.DN(DN), .DW(DW), .LANES(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Reference: stable insertion sort of indices by value.
    function automatic exp_t model(input logic [DW*DN-1:0] data, input logic desc);
        int   idx [DN];
        int   v   [DN];
        int   t;
        exp_t e;
        for (int k = 0; k < DN; k++) begin
            idx[k] = k;
            v[k]   = int'(data[k*DW +: DW]);
        end
        for (int a = 1; a < DN; a++) begin
            for (int b = a; b > 0; b--) begin
                if (desc ? (v[idx[b-1]] < v[idx[b]]) : (v[idx[b-1]] > v[idx[b]])) begin
                    t = idx[b-1]; idx[b-1] = idx[b]; idx[b] = t;
                end else begin
                    break;
                end
            end
        end
        e.rank   = '0;
        e.sorted = '0;
        for (int p = 0; p < DN; p++) begin
            e.rank[idx[p]*RW +: RW] = RW'(p);
            e.sorted[p*DW +: DW]    = DW'(v[idx[p]]);
        end
        if (!c_HAS_SORT) e.sorted = '0;
        e.cyc = 32 + c_EXTRA;
        return e;
    endfunction

    // Start a run on the LANES=2 engine and wait for done (cycle 1 = after the start edge).
    task automatic run_a(input logic [DW*DN-1:0] data, input logic desc, input int extra_start,
                         input int rst_cyc, output int done_cyc, output int busy_low);
        int cyc;
        bit hit_rst;
        done_cyc = -1;
        busy_low = 0;
        hit_rst  = 1'b0;
        @(negedge clk);
        bus_a.data_in = data;
        bus_a.descend = desc;
        bus_a.start   = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        cyc = 1;
        while (cyc <= c_TIMEOUT) begin
            if (bus_a.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (bus_a.busy !== 1'b1) busy_low++;
            if (cyc == extra_start) begin
                bus_a.start   = 1'b1;
                bus_a.data_in = ~data;
                bus_a.descend = ~desc;
            end
            if (cyc == rst_cyc) begin
                rst     = 1'b1;
                hit_rst = 1'b1;
            end
            @(posedge clk); #1;
            bus_a.start = 1'b0;
            if (hit_rst) begin
                rst = 1'b0;
                break;
            end
            cyc++;
        end
    endtask

    task automatic run_b(input logic [DW*DN-1:0] data, input logic desc, output int done_cyc);
        int cyc;
        done_cyc = -1;
        @(negedge clk);
        bus_b.data_in = data;
        bus_b.descend = desc;
        bus_b.start   = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        cyc = 1;
        while (cyc <= c_TIMEOUT) begin
            if (bus_b.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b want 0", bus_a.busy); end
        n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done_a: got %b want 0", bus_a.done); end
        n_checks++; if (bus_a.rank_out !== '0) begin n_fail++; $display("FAIL reset_rank_a: got %h want 0", bus_a.rank_out); end
        n_checks++; if (bus_a.data_sorted !== '0) begin n_fail++; $display("FAIL reset_sorted_a: got %h want 0", bus_a.data_sorted); end
        n_checks++; if (bus_b.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", bus_b.busy); end
        n_checks++; if (bus_b.rank_out !== '0) begin n_fail++; $display("FAIL reset_rank_b: got %h want 0", bus_b.rank_out); end
        rst = 1'b0;
    endtask

    task automatic test_ascending();
        exp_t e;
        int   dc, bl;
        e.rank = c_ASC_RANK; e.sorted = c_HAS_SORT ? c_ASC_SORT : '0; e.cyc = 32 + c_EXTRA;
        sb_q.push_back(e);
        run_a(c_DATA, 1'b0, -1, -1, dc, bl);
        e = sb_q.pop_front();
        n_checks++; if (bus_a.rank_out !== e.rank) begin n_fail++; $display("FAIL asc_rank: got %h want %h", bus_a.rank_out, e.rank); end
        n_checks++; if (bus_a.data_sorted !== e.sorted) begin n_fail++; $display("FAIL asc_sorted: got %h want %h", bus_a.data_sorted, e.sorted); end
        n_checks++; if (dc !== e.cyc) begin n_fail++; $display("FAIL asc_done_cycle: got %0d want %0d", dc, e.cyc); end
        n_checks++; if (bl !== 0) begin n_fail++; $display("FAIL asc_busy: busy low in %0d run cycles, want 0", bl); end
        @(posedge clk); #1;
        n_checks++; if ({bus_a.done, bus_a.busy} !== 2'b00) begin n_fail++; $display("FAIL asc_done_pulse: done,busy got %b want 00", {bus_a.done, bus_a.busy}); end
    endtask

    task automatic test_descending();
        exp_t e;
        int   dc, bl;
        e.rank = c_DSC_RANK; e.sorted = c_HAS_SORT ? c_DSC_SORT : '0; e.cyc = 32 + c_EXTRA;
        sb_q.push_back(e);
        run_a(c_DATA, 1'b1, -1, -1, dc, bl);
        e = sb_q.pop_front();
        n_checks++; if (bus_a.rank_out !== e.rank) begin n_fail++; $display("FAIL dsc_rank: got %h want %h", bus_a.rank_out, e.rank); end
        n_checks++; if (bus_a.data_sorted !== e.sorted) begin n_fail++; $display("FAIL dsc_sorted: got %h want %h", bus_a.data_sorted, e.sorted); end
        n_checks++; if (dc !== e.cyc) begin n_fail++; $display("FAIL dsc_done_cycle: got %0d want %0d", dc, e.cyc); end
        @(posedge clk); #1;
        n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL dsc_done_pulse: got %b want 0", bus_a.done); end
    endtask

    task automatic test_all_equal();
        exp_t e;
        int   dc, bl;
        e.rank = c_IDX_RANK; e.sorted = c_HAS_SORT ? {DN{8'h55}} : '0; e.cyc = 32 + c_EXTRA;
        sb_q.push_back(e);
        run_a({DN{8'h55}}, 1'b1, -1, -1, dc, bl);
        e = sb_q.pop_front();
        n_checks++; if (bus_a.rank_out !== e.rank) begin n_fail++; $display("FAIL eq_rank: got %h want %h", bus_a.rank_out, e.rank); end
        n_checks++; if (bus_a.data_sorted !== e.sorted) begin n_fail++; $display("FAIL eq_sorted: got %h want %h", bus_a.data_sorted, e.sorted); end
        n_checks++; if (dc !== e.cyc) begin n_fail++; $display("FAIL eq_done_cycle: got %0d want %0d", dc, e.cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t             e;
        logic [DW*DN-1:0] d;
        int               dc, bl;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < DN; k++) d[k*DW +: DW] = DW'($urandom_range(0, 7));
            sb_q.push_back(model(d, n[0]));
            run_a(d, n[0], -1, -1, dc, bl);
            e = sb_q.pop_front();
            n_checks++; if (bus_a.rank_out !== e.rank) begin n_fail++; $display("FAIL rnd%0d_rank: got %h want %h", n, bus_a.rank_out, e.rank); end
            n_checks++; if (bus_a.data_sorted !== e.sorted) begin n_fail++; $display("FAIL rnd%0d_sorted: got %h want %h", n, bus_a.data_sorted, e.sorted); end
            n_checks++; if (dc !== e.cyc) begin n_fail++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", n, dc, e.cyc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_masked_lanes();
        exp_t e;
        int   dc;
        e.rank = c_REV_RANK; e.sorted = c_HAS_SORT ? c_REV_SORT : '0; e.cyc = 24 + c_EXTRA;
        sb_q.push_back(e);
        run_b(c_REV_DATA, 1'b0, dc);
        e = sb_q.pop_front();
        n_checks++; if (bus_b.rank_out !== e.rank) begin n_fail++; $display("FAIL l3_rank: got %h want %h", bus_b.rank_out, e.rank); end
        n_checks++; if (bus_b.data_sorted !== e.sorted) begin n_fail++; $display("FAIL l3_sorted: got %h want %h", bus_b.data_sorted, e.sorted); end
        n_checks++; if (dc !== e.cyc) begin n_fail++; $display("FAIL l3_done_cycle: got %0d want %0d", dc, e.cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   dc, bl;
        e.rank = c_ASC_RANK; e.sorted = c_HAS_SORT ? c_ASC_SORT : '0; e.cyc = 32 + c_EXTRA;
        sb_q.push_back(e);
        run_a(c_DATA, 1'b0, 5, -1, dc, bl);
        e = sb_q.pop_front();
        n_checks++; if (bus_a.rank_out !== e.rank) begin n_fail++; $display("FAIL ign_rank: got %h want %h", bus_a.rank_out, e.rank); end
        n_checks++; if (bus_a.data_sorted !== e.sorted) begin n_fail++; $display("FAIL ign_sorted: got %h want %h", bus_a.data_sorted, e.sorted); end
        n_checks++; if (dc !== e.cyc) begin n_fail++; $display("FAIL ign_done_cycle: got %0d want %0d", dc, e.cyc); end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL ign_not_queued%0d: busy got %b want 0", n, bus_a.busy); end
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        int   dc, bl, n_done;
        e.rank = '0; e.sorted = '0; e.cyc = -1;
        sb_q.push_back(e);
        run_a(c_DATA, 1'b1, -1, 10, dc, bl);
        e = sb_q.pop_front();
        n_checks++; if (dc !== e.cyc) begin n_fail++; $display("FAIL rst_no_early_done: got cycle %0d want %0d", dc, e.cyc); end
        n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus_a.busy); end
        n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus_a.done); end
        n_checks++; if (bus_a.rank_out !== e.rank) begin n_fail++; $display("FAIL rst_rank: got %h want %h", bus_a.rank_out, e.rank); end
        n_checks++; if (bus_a.data_sorted !== e.sorted) begin n_fail++; $display("FAIL rst_sorted: got %h want %h", bus_a.data_sorted, e.sorted); end
        n_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus_a.done === 1'b1) n_done++;
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL rst_run_discarded: done pulses got %0d want 0", n_done); end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.descend = 1'b0; bus_a.data_in = '0;
        bus_b.start = 1'b0; bus_b.descend = 1'b0; bus_b.data_in = '0;
        test_reset();
        test_ascending();
        test_descending();
        test_all_equal();
        test_random();
        test_masked_lanes();
        test_start_ignored();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
